board_access_arbiter: RTL and testbench

//  Shares the single-port board RAM (one 2-bit cell per square) between the display scanner, player shots and PC shots.

---
 rtl/board_access_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_board_access_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_access_arbiter.sv
// Board RAM arbiter: pipelined display reads plus read-modify-write player/PC shots with hit tracking.
// Optional display-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module board_access_arbiter #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned SHIP_CELLS = 17,
    parameter int unsigned MAX_STREAK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_ack_o,
    output logic              disp_valid_o,
    output logic [1:0]        disp_data_o,
    input  logic              ply_req_i,
    input  logic [ADDR_W-1:0] ply_addr_i,
    output logic              ply_ack_o,
    input  logic              pc_req_i,
    input  logic [ADDR_W-1:0] pc_addr_i,
    output logic              pc_ack_o,
    output logic [1:0]        result_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [1:0]        ram_wdata_o,
    input  logic [1:0]        ram_rdata_i,
    output logic [7:0]        hits_count_o,
    output logic              game_over_o
);

    localparam int unsigned HITS_W = 8;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    localparam logic [1:0] RES_MISS   = 2'b00;
    localparam logic [1:0] RES_HIT    = 2'b01;
    localparam logic [1:0] RES_REPEAT = 2'b10;
    localparam logic [1:0] RES_REJECT = 2'b11;

    // Elaboration-time sanity of the configuration.
    if (SHIP_CELLS == 0 || SHIP_CELLS > 255) begin : g_bad_ship_cells
        $error("board_access_arbiter: SHIP_CELLS must be 1..255");
    end
    if (MAX_STREAK == 0) begin : g_bad_max_streak
        $error("board_access_arbiter: MAX_STREAK must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        EVAL = 2'b10,
        WR   = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;          // 1: PC preferred on a tie
    logic                gnt_pc_q, gnt_pc_d;  // owner of the in-flight RMW
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [1:0]          ram_wdata_q, ram_wdata_d;
    logic                ply_ack_q, ply_ack_d;
    logic                pc_ack_q, pc_ack_d;
    logic [1:0]          result_q, result_d;
    logic [HITS_W-1:0]   hits_q, hits_d;
    logic                game_over_q, game_over_d;
    logic [1:0]          disp_pipe_q, disp_pipe_d;

    logic                disp_ack_c;
    logic                shot_gnt;
    logic                guard_win;
    logic                ply_pend;
    logic                pc_pend;
    logic                shot_pend;
    logic                sel_pc;

    // A requester still holding req in the cycle its ack is visible is not a new request.
    assign ply_pend  = ply_req_i & ~ply_ack_q;
    assign pc_pend   = pc_req_i & ~pc_ack_q;
    assign shot_pend = ply_pend | pc_pend;
    assign sel_pc    = pc_pend & (~ply_pend | rr_q);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;

    assign guard_win = shot_pend && (streak_q == STREAK_W'(MAX_STREAK));

    // Consecutive display grants taken while a shot waits.
    always_comb begin
        streak_d = streak_q;
        if (!shot_pend || shot_gnt) begin
            streak_d = '0;
        end else if (disp_ack_c && (streak_q != STREAK_W'(MAX_STREAK))) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign guard_win = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_pc_d    = gnt_pc_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = 2'b00;
        ply_ack_d   = 1'b0;
        pc_ack_d    = 1'b0;
        result_d    = 2'b00;
        hits_d      = hits_q;
        disp_ack_c  = 1'b0;
        shot_gnt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (disp_req_i && !guard_win) begin
                    disp_ack_c = 1'b1;
                    ram_addr_d = disp_addr_i;
                end else if (shot_pend) begin
                    shot_gnt = 1'b1;
                    rr_d     = ~sel_pc;
                    gnt_pc_d = sel_pc;
                    if (game_over_q) begin
                        // Board is finished: reject without touching the RAM.
                        ply_ack_d = ~sel_pc;
                        pc_ack_d  = sel_pc;
                        result_d  = RES_REJECT;
                    end else begin
                        ram_addr_d = sel_pc ? pc_addr_i : ply_addr_i;
                        state_d    = RD;
                    end
                end
            end
            RD: begin
                state_d = EVAL;
            end
            EVAL: begin
                ply_ack_d = ~gnt_pc_q;
                pc_ack_d  = gnt_pc_q;
                state_d   = WR;
                case (ram_rdata_i)
                    CELL_EMPTY: begin
                        ram_we_d    = 1'b1;
                        ram_wdata_d = CELL_MISS;
                        result_d    = RES_MISS;
                    end
                    CELL_SHIP: begin
                        ram_we_d    = 1'b1;
                        ram_wdata_d = CELL_HIT;
                        result_d    = RES_HIT;
                        if (hits_q != '1) begin
                            hits_d = hits_q + HITS_W'(1);
                        end
                    end
                    default: begin
                        result_d = RES_REPEAT;
                    end
                endcase
            end
            WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky once the hit count reaches the fleet size.
    assign game_over_d = game_over_q | (hits_q == HITS_W'(SHIP_CELLS));
    assign disp_pipe_d = {disp_pipe_q[0], disp_ack_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            gnt_pc_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 2'b00;
            ply_ack_q   <= 1'b0;
            pc_ack_q    <= 1'b0;
            result_q    <= 2'b00;
            hits_q      <= '0;
            game_over_q <= 1'b0;
            disp_pipe_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_pc_q    <= gnt_pc_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            ply_ack_q   <= ply_ack_d;
            pc_ack_q    <= pc_ack_d;
            result_q    <= result_d;
            hits_q      <= hits_d;
            game_over_q <= game_over_d;
            disp_pipe_q <= disp_pipe_d;
        end
    end

    // Grant is same-cycle; read data comes straight from the RAM's output register.
    assign disp_ack_o   = disp_ack_c & ~rst;
    assign disp_valid_o = disp_pipe_q[1];
    assign disp_data_o  = disp_pipe_q[1] ? ram_rdata_i : 2'b00;

    assign ply_ack_o    = ply_ack_q;
    assign pc_ack_o     = pc_ack_q;
    assign result_o     = result_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_we_o     = ram_we_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign hits_count_o = hits_q;
    assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_board_access_arbiter.sv
// Directed bench for board_access_arbiter with a behavioural 1-cycle board RAM.
module tb_board_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_req;
    logic [5:0] disp_addr;
    logic       disp_ack;
    logic       disp_valid;
    logic [1:0] disp_data;
    logic       ply_req;
    logic [5:0] ply_addr;
    logic       ply_ack;
    logic       pc_req;
    logic [5:0] pc_addr;
    logic       pc_ack;
    logic [1:0] result;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [1:0] ram_wdata;
    logic [1:0] ram_rdata;
    logic [7:0] hits_count;
    logic       game_over;

    int checks   = 0;
    int failures = 0;
    int we_cnt;
    int n;
    int acks;
    bit seen;

    logic [1:0] mem [64];
    logic       clr;
    logic       pre_we;
    logic [5:0] pre_addr;
    logic [1:0] pre_data;

    always #5 clk = ~clk;

    board_access_arbiter #(
        .ADDR_W    (6),
        .SHIP_CELLS(2),
        .MAX_STREAK(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_req_i  (disp_req),
        .disp_addr_i (disp_addr),
        .disp_ack_o  (disp_ack),
        .disp_valid_o(disp_valid),
        .disp_data_o (disp_data),
        .ply_req_i   (ply_req),
        .ply_addr_i  (ply_addr),
        .ply_ack_o   (ply_ack),
        .pc_req_i    (pc_req),
        .pc_addr_i   (pc_addr),
        .pc_ack_o    (pc_ack),
        .result_o    (result),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .hits_count_o(hits_count),
        .game_over_o (game_over)
    );

    // Board RAM model with a bench-side preload port.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 2'b00;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Advance until an ack, counting cycles and RAM writes; bounded.
    task automatic wait_ack(input string tag, output int cyc);
        cyc    = 0;
        we_cnt = 0;
        do begin
            step();
            cyc++;
            if (ram_we) we_cnt++;
        end while (!(ply_ack || pc_ack) && cyc < 20);
        check({tag, "_ack_seen"}, 32'(ply_ack | pc_ack), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        disp_req = 1'b0; disp_addr = '0; ply_req = 1'b0; ply_addr = '0;
        pc_req = 1'b0; pc_addr = '0;
        step();
        step();
        clr = 1'b0;
        // Reset state
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_acks", 32'({ply_ack, pc_ack, disp_ack, disp_valid}), 32'd0);
        check("rst_hits", 32'(hits_count), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        rst = 1'b0;
        step();

        // Test 1: player hits a ship cell
        preload(6'd5, 2'b01);
        preload(6'd9, 2'b10);
        ply_addr = 6'd5; ply_req = 1'b1;
        wait_ack("t1", n);
        check("t1_latency", 32'(n), 32'd3);
        check("t1_ply_ack", 32'({ply_ack, pc_ack}), 32'b10);
        check("t1_result", 32'(result), 32'b01);
        check("t1_we", 32'(ram_we), 32'd1);
        check("t1_wdata", 32'(ram_wdata), 32'b11);
        check("t1_addr", 32'(ram_addr), 32'd5);
        check("t1_we_cnt", 32'(we_cnt), 32'd1);
        check("t1_hits", 32'(hits_count), 32'd1);
        ply_req = 1'b0;
        step();
        check("t1_cell", 32'(mem[5]), 32'b11);
        check("t1_no_reack", 32'(ply_ack), 32'd0);

        // Test 2: PC repeats a miss cell
        pc_addr = 6'd9; pc_req = 1'b1;
        wait_ack("t2", n);
        check("t2_latency", 32'(n), 32'd3);
        check("t2_pc_ack", 32'({ply_ack, pc_ack}), 32'b01);
        check("t2_result", 32'(result), 32'b10);
        check("t2_we_cnt", 32'(we_cnt), 32'd0);
        check("t2_hits", 32'(hits_count), 32'd1);
        pc_req = 1'b0;
        step();
        check("t2_cell", 32'(mem[9]), 32'b10);

        // Display pipeline, then a shot right behind the reads
        preload(6'd3, 2'b01);
        preload(6'd4, 2'b10);
        disp_addr = 6'd3; disp_req = 1'b1;
        #1;
        check("d_ack0", 32'(disp_ack), 32'd1);
        check("d_valid0", 32'(disp_valid), 32'd0);
        step();
        disp_addr = 6'd4;
        #1;
        check("d_ack1", 32'(disp_ack), 32'd1);
        check("d_valid1", 32'(disp_valid), 32'd0);
        step();
        disp_req = 1'b0; ply_addr = 6'd6; ply_req = 1'b1;
        #1;
        check("d_ack2", 32'(disp_ack), 32'd0);
        check("d_valid2", 32'(disp_valid), 32'd1);
        check("d_data2", 32'(disp_data), 32'b01);
        step();
        check("d_valid3", 32'(disp_valid), 32'd1);
        check("d_data3", 32'(disp_data), 32'b10);
        disp_req = 1'b1; disp_addr = 6'd3;
        #1;
        check("d_ack_busy", 32'(disp_ack), 32'd0);
        disp_req = 1'b0;
        wait_ack("d_shot", n);
        check("d_shot_latency", 32'(n), 32'd2);
        check("d_shot_result", 32'(result), 32'b00);
        check("d_shot_wdata", 32'({ram_we, ram_wdata}), 32'b110);
        ply_req = 1'b0;
        step();
        check("d_valid_off", 32'(disp_valid), 32'd0);

        // Test 3: round-robin ties
        do_reset();
        ply_addr = 6'd40; pc_addr = 6'd41; ply_req = 1'b1; pc_req = 1'b1;
        wait_ack("t3a", n);
        check("t3a_latency", 32'(n), 32'd3);
        check("t3a_who", 32'({ply_ack, pc_ack}), 32'b10);
        check("t3a_addr", 32'(ram_addr), 32'd40);
        ply_req = 1'b0;
        wait_ack("t3b", n);
        check("t3b_latency", 32'(n), 32'd4);
        check("t3b_who", 32'({ply_ack, pc_ack}), 32'b01);
        check("t3b_addr", 32'(ram_addr), 32'd41);
        pc_req = 1'b0;
        step();
        ply_addr = 6'd42; ply_req = 1'b1;
        wait_ack("t3c", n);
        check("t3c_who", 32'({ply_ack, pc_ack}), 32'b10);
        ply_req = 1'b0;
        step();
        ply_addr = 6'd43; pc_addr = 6'd44; ply_req = 1'b1; pc_req = 1'b1;
        wait_ack("t3d", n);
        check("t3d_who", 32'({ply_ack, pc_ack}), 32'b01);
        check("t3d_addr", 32'(ram_addr), 32'd44);
        pc_req = 1'b0;
        wait_ack("t3e", n);
        check("t3e_who", 32'({ply_ack, pc_ack}), 32'b10);
        check("t3e_addr", 32'(ram_addr), 32'd43);
        check("t3_hits", 32'(hits_count), 32'd0);
        ply_req = 1'b0;
        step();

        // Test 4: display held high against a pending shot
        disp_addr = 6'd7; disp_req = 1'b1; ply_addr = 6'd45; ply_req = 1'b1;
        acks = 0; seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (disp_ack) acks++;
            if (ply_ack) begin
                seen = 1'b1;
                ply_req = 1'b0;
            end
            step();
        end
`ifdef ARB_STARVE_GUARD_EN
        check("t4_disp_acks", 32'(acks), 32'd8);
        check("t4_ply_served", 32'(seen), 32'd1);
        disp_req = 1'b0;
        step();
`else
        check("t4_disp_acks", 32'(acks), 32'd12);
        check("t4_ply_waits", 32'(seen), 32'd0);
        disp_req = 1'b0;
        wait_ack("t4", n);
        check("t4_latency", 32'(n), 32'd3);
        check("t4_who", 32'({ply_ack, pc_ack}), 32'b10);
        ply_req = 1'b0;
        step();
`endif
        check("t4_cell", 32'(mem[45]), 32'b10);

        // Test 5: game over after two hits
        do_reset();
        preload(6'd50, 2'b01);
        preload(6'd51, 2'b01);
        preload(6'd52, 2'b01);
        ply_addr = 6'd50; ply_req = 1'b1;
        wait_ack("t5a", n);
        check("t5a_result", 32'(result), 32'b01);
        ply_req = 1'b0;
        step();
        check("t5a_go", 32'(game_over), 32'd0);
        pc_addr = 6'd51; pc_req = 1'b1;
        wait_ack("t5b", n);
        check("t5b_result", 32'(result), 32'b01);
        check("t5b_hits", 32'(hits_count), 32'd2);
        check("t5b_go_early", 32'(game_over), 32'd0);
        pc_req = 1'b0;
        step();
        check("t5b_go", 32'(game_over), 32'd1);
        ply_addr = 6'd52; ply_req = 1'b1;
        wait_ack("t5c", n);
        check("t5c_latency", 32'(n), 32'd1);
        check("t5c_who", 32'({ply_ack, pc_ack}), 32'b10);
        check("t5c_result", 32'(result), 32'b11);
        check("t5c_we_cnt", 32'(we_cnt), 32'd0);
        check("t5c_hits", 32'(hits_count), 32'd2);
        ply_req = 1'b0;
        step();
        check("t5c_no_reack", 32'(ply_ack), 32'd0);
        check("t5c_cell", 32'(mem[52]), 32'b01);
        disp_addr = 6'd52; disp_req = 1'b1;
        #1;
        check("t5_disp_ack", 32'(disp_ack), 32'd1);
        step();
        disp_req = 1'b0;
        step();
        check("t5_disp_data", 32'({disp_valid, disp_data}), 32'b101);
        check("t5_go_sticky", 32'(game_over), 32'd1);

        // Test 6: reset during EVAL aborts the RMW
        step();
        do_reset();
        ply_addr = 6'd30; ply_req = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_addr", 32'(ram_addr), 32'd0);
        check("t6_rst_outs", 32'({ram_we, ply_ack, pc_ack, result}), 32'd0);
        check("t6_rst_hits", 32'({hits_count, game_over}), 32'd0);
        ply_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (ram_we || ply_ack) we_cnt++;
            step();
        end
        check("t6_no_activity", 32'(we_cnt), 32'd0);
        check("t6_cell_kept", 32'(mem[30]), 32'b00);
        ply_req = 1'b1;
        wait_ack("t6", n);
        check("t6_latency", 32'(n), 32'd3);
        check("t6_result", 32'(result), 32'b00);
        check("t6_wdata", 32'({ram_we, ram_wdata}), 32'b110);
        ply_req = 1'b0;
        step();
        check("t6_cell", 32'(mem[30]), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
